// File: rtl/adc_sample_avg.sv
// Moving-average filter over the last 2**DEPTH_LOG2 ADC samples, plus optional min/max peak hold.
// Define ADC_AVG_PEAK_HOLD_EN to compile in the peak tracking; otherwise o_max/o_min are constants.
module adc_sample_avg #(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   input  logic       i_peak_clr,
   output logic [7:0] o_avg,
   output logic       o_avg_valid,
   output logic       o_full,
   output logic [7:0] o_max,
   output logic [7:0] o_min
);

   localparam int N     = 1 << DEPTH_LOG2;
   localparam int SUM_W = 8 + DEPTH_LOG2;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                  state;
   logic [7:0]              sample_buf [N];
   logic [DEPTH_LOG2-1:0]   wptr;
   logic [SUM_W-1:0]        sum;
   logic [SUM_W-1:0]        sum_next;

   // Subtracting the outgoing sample first keeps the intermediate within N*255.
   always_comb begin
      sum_next = sum - SUM_W'(sample_buf[wptr]) + SUM_W'(i_data);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < N; i++) begin
            sample_buf[i] <= '0;
         end
         wptr        <= '0;
         sum         <= '0;
         state       <= FILL;
         o_avg       <= '0;
         o_avg_valid <= 1'b0;
         o_full      <= 1'b0;
      end else begin
         o_avg_valid <= i_valid;
         if (i_valid) begin
            sample_buf[wptr] <= i_data;
            wptr             <= wptr + 1'b1;
            sum              <= sum_next;
            o_avg            <= sum_next[SUM_W-1:DEPTH_LOG2];
            case (state)
               FILL: begin
                  if (wptr == DEPTH_LOG2'(N - 1)) begin
                     state  <= RUN;
                     o_full <= 1'b1;
                  end
               end
               RUN: begin
                  o_full <= 1'b1;
               end
               default: begin
                  state  <= FILL;
                  o_full <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef ADC_AVG_PEAK_HOLD_EN
   // A clear coinciding with a sample restarts tracking from that sample.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_max <= 8'h00;
         o_min <= 8'hFF;
      end else if (i_peak_clr && i_valid) begin
         o_max <= i_data;
         o_min <= i_data;
      end else if (i_peak_clr) begin
         o_max <= 8'h00;
         o_min <= 8'hFF;
      end else if (i_valid) begin
         if (i_data > o_max) begin
            o_max <= i_data;
         end
         if (i_data < o_min) begin
            o_min <= i_data;
         end
      end
   end
`else
   logic peak_clr_unused;

   assign peak_clr_unused = i_peak_clr;
   assign o_max           = 8'h00;
   assign o_min           = 8'hFF;
`endif

endmodule

// File: doc/adc_sample_avg.md
ADC_SAMPLE_AVG -- requirements
Module: adc_sample_avg

Interface
REQ-001 Parameter DEPTH_LOG2, default 3, log2 of the averaging window; window N = 2^DEPTH_LOG2, legal range 1..5.
REQ-002 i_clk  input  1  system clock (50 MHz).
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_data  input  8  unsigned ADC sample from the TLC549 driver.
REQ-005 i_valid  input  1  one-cycle strobe; i_data is a new sample; back-to-back strobes allowed.
REQ-006 i_peak_clr  input  1  one-cycle request to restart min/max tracking.
REQ-007 o_avg  output  8  moving average of the last N samples, fed to the BCD stage.
REQ-008 o_avg_valid  output  1  one-cycle pulse; o_avg just updated.
REQ-009 o_full  output  1  high once N samples have been accepted since reset.
REQ-010 o_max  output  8  largest sample since the last clear.
REQ-011 o_min  output  8  smallest sample since the last clear.

Function
REQ-012 Block SHALL hold an N-entry circular sample buffer, a write pointer of DEPTH_LOG2 bits and a running sum of 8+DEPTH_LOG2 bits.
REQ-013 On i_valid, block SHALL in one cycle: sum <= sum + i_data - buf[wptr]; buf[wptr] <= i_data; wptr <= wptr+1, wrapping from N-1 to 0.
REQ-014 o_avg SHALL equal floor(sum / N), i.e. sum >> DEPTH_LOG2, registered; it SHALL change only in the cycle after an i_valid.
REQ-015 o_avg_valid SHALL pulse exactly one cycle, one cycle after each i_valid; latency i_valid -> o_avg = 1 clock.
REQ-016 Sum arithmetic SHALL never overflow or underflow; the sum width covers N*255.
REQ-017 Buffer entries SHALL be zero after reset; during fill the average ramps, with empty slots counted as 0.
REQ-018 Control FSM SHALL have states FILL and RUN: reset -> FILL; FILL -> RUN on the i_valid that writes slot N-1; RUN is held until reset.
REQ-019 o_full SHALL be 0 in FILL and 1 in RUN, asserted together with the o_avg_valid of the Nth sample.
REQ-020 With i_valid low, all state SHALL hold.
REQ-021 Peak tracking: on i_valid, o_max <= max(o_max, i_data) and o_min <= min(o_min, i_data).
REQ-022 i_peak_clr alone SHALL set o_max=8'h00 and o_min=8'hFF next cycle.
REQ-023 i_peak_clr and i_valid in the same cycle SHALL load i_data into both o_max and o_min; the averaging path is unaffected.

Reset
REQ-024 i_rst high SHALL immediately, without a clock, force: o_avg=0, o_avg_valid=0, o_full=0, o_max=8'h00, o_min=8'hFF, sum=0, wptr=0, all buffer entries 0, state FILL.
REQ-025 Reset asserted mid-stream SHALL discard the partial window; the first valid after release is treated as sample 1 of a new fill.

Configuration
REQ-026 Macro ADC_AVG_PEAK_HOLD_EN: when defined, REQ-021..023 min/max logic SHALL be compiled in.
REQ-027 When ADC_AVG_PEAK_HOLD_EN is undefined, o_max SHALL be tied to 8'h00 and o_min to 8'hFF, i_peak_clr SHALL be ignored, and no peak registers SHALL be synthesized; averaging behaviour SHALL be unchanged.

Verification
REQ-028 Reset pulse mid-run -> outputs immediately at reset values (o_min=FF, all else 0); o_full=0.
REQ-029 DEPTH_LOG2=3, eight back-to-back valids of 100 -> o_avg 12,25,37,50,62,75,87,100 on successive cycles; o_full rises with the 8th o_avg_valid.
REQ-030 After REQ-029, one valid of 200 -> o_avg=112 (sum 900); o_avg_valid single pulse.
REQ-031 Then eight valids of 0 -> wrap exercised; final o_avg=0; o_full stays 1.
REQ-032 PEAK_HOLD_EN defined: samples 10,250,3 -> o_max=250, o_min=3; i_peak_clr with i_valid of 77 -> o_max=o_min=77; clr alone -> 00/FF.
REQ-033 PEAK_HOLD_EN undefined: same stimulus as REQ-032 -> o_max=00, o_min=FF throughout; averages as in REQ-029.
